// File: rtl/papa_arb_pkg.sv
// papa_arb_pkg: shared types, limits and helpers for the
// round-robin arbiter that fronts the papa m1 datapath.
package papa_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_MAX_REQ = 16;

  function automatic int arb_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/papa_rr_pick.sv
// papa_rr_pick: combinational rotating-priority picker built as a
// double-width masked priority encoder starting at ptr.
module papa_rr_pick
  import papa_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = arb_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_id,
  output logic          any
);

  logic [N-1:0]   lo;
  logic [2*N-1:0] dbl;
  logic [IW:0]    idx;

  // Lower copy keeps only bits at or above ptr; upper copy wraps.
  always_comb begin
    lo  = req & ~((N'(1) << ptr) - N'(1));
    dbl = {req, lo};
    idx = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) begin
        idx = (IW+1)'(i);
      end
    end
    any = |req;
    if (idx >= (IW+1)'(N)) begin
      win_id = IW'(idx - (IW+1)'(N));
    end else begin
      win_id = IW'(idx);
    end
    win = any ? (N'(1) << win_id) : '0;
  end

endmodule

// File: rtl/papa_rr_arb.sv
// papa_rr_arb: round-robin grant sequencer for the shared m1 resource.
// Optional grant timeout is compiled in with PAPA_ARB_TIMEOUT_EN.
module papa_rr_arb
  import papa_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int TO_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     done,
  output logic [N_REQ-1:0]         gnt,
  output logic                     gnt_vld,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     to_err
);

  localparam int IW = arb_idx_w(N_REQ);

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [N_REQ-1:0] win;
  logic [IW-1:0]   win_id;
  logic            any;
  logic            to_hit;
  logic            rel;
  logic            arb_en;
  logic [IW-1:0]   ptr_nxt;

  papa_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .win    (win),
    .win_id (win_id),
    .any    (any)
  );

  // Release on done or expiry; arbitrate when idle or releasing.
  always_comb begin
    rel     = (state == BUSY) && (done || to_hit);
    arb_en  = (state == IDLE) || rel;
    ptr_nxt = (win_id == IW'(N_REQ-1)) ? '0 : win_id + IW'(1);
  end

  // Grant FSM with registered grant, id and pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_id  <= '0;
    end else if (arb_en) begin
      if (any) begin
        state   <= BUSY;
        gnt     <= win;
        gnt_vld <= 1'b1;
        gnt_id  <= win_id;
        ptr     <= ptr_nxt;
      end else begin
        state   <= IDLE;
        gnt     <= '0;
        gnt_vld <= 1'b0;
      end
    end
  end

  assign busy = (state == BUSY);

`ifdef PAPA_ARB_TIMEOUT_EN
  logic [15:0] cnt;

  assign to_hit = (state == BUSY) && !done &&
                  (cnt == 16'(TO_CYC-1));

  // Cycles since grant; cleared at every arbitration point.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (arb_en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // One-cycle error pulse aligned with the forced release edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_err <= 1'b0;
    end else begin
      to_err <= to_hit;
    end
  end
`else
  assign to_hit = 1'b0;
  assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_papa_rr_arb.sv
// tb_papa_rr_arb: directed plus random checks of papa_rr_arb
// against a behavioural round-robin model.
module tb_papa_rr_arb;

  localparam int N  = 4;
  localparam int TO = 8;
`ifdef PAPA_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic [N-1:0] gnt;
  logic         gnt_vld;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         to_err;

  int total = 0;
  int bad   = 0;

  int m_busy = 0;
  int m_id   = 0;
  int m_ptr  = 0;
  int m_age  = 0;
  int m_to   = 0;

  papa_rr_arb #(
    .N_REQ  (N),
    .TO_CYC (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .to_err  (to_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int find_win(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    int expire;
    int relse;
    expire = (TO_EN && m_busy == 1 && m_age == TO - 1) ? 1 : 0;
    m_to = 0;
    if (rst) begin
      m_busy = 0; m_id = 0; m_ptr = 0; m_age = 0;
    end else begin
      relse = (m_busy == 1 && (done || expire == 1)) ? 1 : 0;
      if (m_busy == 0 || relse == 1) begin
        m_to = (relse == 1 && !done) ? 1 : 0;
        w = find_win(req, m_ptr);
        m_age = 0;
        if (w >= 0) begin
          m_busy = 1; m_id = w; m_ptr = (w + 1) % N;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic tick(input logic [N-1:0] r, input logic d,
                      input logic rs);
    logic [N-1:0] eg;
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_busy == 1) ? N'(1 << m_id) : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_vld", 32'(gnt_vld), 32'(m_busy));
    chk("gnt_id", 32'(gnt_id), 32'(m_id));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("to_err", 32'(to_err), 32'(m_to));
  endtask

  initial begin
    int exp_seq [4] = '{1, 2, 3, 0};
    int k;
    logic [N-1:0] r;
    logic d;
    logic rs;

    tick('0, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    tick(4'b0100, 1'b0, 1'b0);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_id", 32'(gnt_id), 32'd2);
    tick('0, 1'b1, 1'b0);
    chk("single_rel", 32'(gnt), 32'h0);
    chk("single_idle", 32'(busy), 32'h0);

    tick('0, 1'b0, 1'b1);
    tick(4'b1111, 1'b0, 1'b0);
    chk("fair_first", 32'(gnt_id), 32'd0);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      tick(4'b1111, (i % 3 == 2), 1'b0);
      chk("fair_vld", 32'(gnt_vld), 32'h1);
      if (i % 3 == 2) begin
        chk("fair_order", 32'(gnt_id), 32'(exp_seq[k]));
        k++;
      end
    end

    tick('0, 1'b0, 1'b1);
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0101, 1'b1, 1'b0);
    chk("wrap_0", 32'(gnt_id), 32'd0);
    tick(4'b0101, 1'b1, 1'b0);
    chk("skip_2", 32'(gnt_id), 32'd2);
    tick('0, 1'b1, 1'b0);

    tick('0, 1'b0, 1'b1);
    tick(4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick('0, 1'b0, 1'b0);
      chk("drop_hold", 32'(gnt), 32'h2);
    end
    tick('0, 1'b1, 1'b0);
    chk("drop_rel", 32'(gnt), 32'h0);

    tick('0, 1'b0, 1'b1);
    tick(4'b1000, 1'b0, 1'b0);
    chk("mid_gnt", 32'(gnt), 32'h8);
    tick(4'b1000, 1'b1, 1'b1);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_id", 32'(gnt_id), 32'h0);
    tick(4'b1001, 1'b0, 1'b0);
    chk("mid_win0", 32'(gnt_id), 32'd0);

    tick('0, 1'b0, 1'b1);
    tick(4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) begin
      tick(4'b0011, 1'b0, 1'b0);
      chk("to_quiet", 32'(to_err), 32'h0);
    end
    tick(4'b0011, 1'b0, 1'b0);
    if (TO_EN) begin
      chk("to_pulse", 32'(to_err), 32'h1);
      chk("to_move", 32'(gnt), 32'h2);
      for (int i = 0; i < TO - 1; i++) tick(4'b0011, 1'b0, 1'b0);
      tick(4'b0011, 1'b1, 1'b0);
      chk("to_coinc", 32'(to_err), 32'h0);
      chk("to_coinc_gnt", 32'(gnt), 32'h1);
    end else begin
      chk("nto_hold", 32'(gnt), 32'h1);
      chk("nto_err", 32'(to_err), 32'h0);
    end

    for (int i = 0; i < 2000; i++) begin
      r  = N'($urandom_range(0, 15));
      d  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 63) == 0);
      tick(r, d, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
